// File: rtl/verify_sequencer.sv
// verify_sequencer: loads one Dilithium verify job (rho, c, z, t1, h, msg length and
// message) into the core in the configured order, then collects the verdict.
module verify_sequencer #(
    parameter int unsigned W          = 64,
    parameter int unsigned HIGH_PERF  = 1,
    parameter int unsigned SEED_WORDS = 4,
    parameter int unsigned Z_WORDS    = 80,
    parameter int unsigned T1_WORDS   = 40,
    parameter int unsigned H_WORDS    = 11,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [31:0]   msg_len,
    output logic          busy,
    output logic          done,
    output logic          accept,
    output logic [31:0]   total_cycles,
    output logic [2:0]    src_seg,
    output logic [15:0]   src_idx,
    input  logic [W-1:0]  src_data,
    output logic          core_rst,
    output logic          core_start,
    output logic          core_valid,
    output logic [W-1:0]  core_data,
    input  logic          core_ready,
    input  logic          res_valid,
    input  logic [W-1:0]  res_data,
    output logic          res_ready
);

    localparam int unsigned IDX_W  = 32;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CYC_W  = 32;
    localparam int unsigned BITS_W = 64;
    localparam int unsigned SEG_W  = 3;

    localparam logic [SEG_W-1:0] SEG_RHO = 3'd0;
    localparam logic [SEG_W-1:0] SEG_C   = 3'd1;
    localparam logic [SEG_W-1:0] SEG_Z   = 3'd2;
    localparam logic [SEG_W-1:0] SEG_T1  = 3'd3;
    localparam logic [SEG_W-1:0] SEG_H   = 3'd4;
    localparam logic [SEG_W-1:0] SEG_MSG = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRST,
        S_CSTART,
        S_RHO,
        S_C,
        S_Z,
        S_T1,
        S_MLEN,
        S_MSG,
        S_H,
        S_GAP,
        S_RESULT
    } state_t;

    state_t             r_state;
    state_t             r_gap_tgt;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CYC_W-1:0]   r_cyc;
    logic [31:0]        r_msg_len;
    logic               r_busy;
    logic               r_done;
    logic               r_accept;
    logic [CYC_W-1:0]   r_total;
    logic [SEG_W-1:0]   r_src_seg;
    logic               r_core_rst;
    logic               r_core_start;
    logic               r_core_valid;
    logic               r_res_ready;

    state_t             w_next;
    state_t             w_succ;
    state_t             w_tgt;
    state_t             w_enter;
    logic               w_xfer;
    logic               w_last;
    logic               w_next_load;
    logic               w_in_run;
    logic [SEG_W-1:0]   w_next_seg;
    logic [BITS_W-1:0]  w_msg_bits;
    logic [BITS_W-1:0]  w_idx_bits;
    logic [CYC_W-1:0]   w_cyc_inc;

    assign w_xfer     = r_core_valid & core_ready;
    assign w_msg_bits = BITS_W'(r_msg_len) << 3;
    assign w_idx_bits = BITS_W'(r_idx + IDX_W'(1)) * BITS_W'(W);
    assign w_cyc_inc  = (r_cyc == '1) ? r_cyc : r_cyc + CYC_W'(1);
    assign w_in_run   = (r_state != S_IDLE) && (r_state != S_CRST) && (r_state != S_CSTART);

    // Last word of the current segment (MLEN is always a single word).
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_RHO, S_C: w_last = (r_idx == IDX_W'(SEED_WORDS - 1));
            S_Z:        w_last = (r_idx == IDX_W'(Z_WORDS - 1));
            S_T1:       w_last = (r_idx == IDX_W'(T1_WORDS - 1));
            S_H:        w_last = (r_idx == IDX_W'(H_WORDS - 1));
            S_MLEN:     w_last = 1'b1;
            S_MSG:      w_last = (w_idx_bits >= w_msg_bits);
            default:    w_last = 1'b0;
        endcase
    end

    // Logical successor segment for the selected core variant.
    always_comb begin
        w_succ = S_RESULT;
        if (HIGH_PERF != 0) begin
            case (r_state)
                S_RHO:   w_succ = S_C;
                S_C:     w_succ = S_Z;
                S_Z:     w_succ = S_T1;
                S_T1:    w_succ = S_MLEN;
                S_MLEN:  w_succ = S_MSG;
                S_MSG:   w_succ = S_H;
                default: w_succ = S_RESULT;
            endcase
        end else begin
            case (r_state)
                S_RHO:   w_succ = S_T1;
                S_T1:    w_succ = S_C;
                S_C:     w_succ = S_Z;
                S_Z:     w_succ = S_H;
                S_H:     w_succ = S_MLEN;
                S_MLEN:  w_succ = S_MSG;
                default: w_succ = S_RESULT;
            endcase
        end
    end

    // An empty message skips MSG together with the gap that precedes it.
    always_comb begin
        w_tgt = w_succ;
        if ((w_succ == S_MSG) && (r_msg_len == 32'd0)) begin
            w_tgt = (HIGH_PERF != 0) ? S_H : S_RESULT;
        end
        w_enter = w_tgt;
        if ((GAP_CYCLES != 0) &&
            ((w_tgt == S_MSG) || ((HIGH_PERF != 0) && (w_tgt == S_H)))) begin
            w_enter = S_GAP;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next = (RST_CYCLES == 0) ? S_CSTART : S_CRST;
                end
            end
            S_CRST: begin
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_next = S_CSTART;
                end
            end
            S_CSTART: w_next = S_RHO;
            S_RHO, S_C, S_Z, S_T1, S_MLEN, S_MSG, S_H: begin
                if (w_xfer && w_last) begin
                    w_next = w_enter;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_next = r_gap_tgt;
                end
            end
            S_RESULT: begin
                if (res_valid) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Segment code and data-phase flag for the upcoming state.
    always_comb begin
        w_next_seg  = '0;
        w_next_load = 1'b0;
        case (w_next)
            S_RHO:         begin w_next_seg = SEG_RHO; w_next_load = 1'b1; end
            S_C:           begin w_next_seg = SEG_C;   w_next_load = 1'b1; end
            S_Z:           begin w_next_seg = SEG_Z;   w_next_load = 1'b1; end
            S_T1:          begin w_next_seg = SEG_T1;  w_next_load = 1'b1; end
            S_H:           begin w_next_seg = SEG_H;   w_next_load = 1'b1; end
            S_MSG, S_MLEN: begin w_next_seg = SEG_MSG; w_next_load = 1'b1; end
            default:       begin w_next_seg = '0;      w_next_load = 1'b0; end
        endcase
    end

    // State register plus all registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gap_tgt    <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_cyc        <= '0;
            r_msg_len    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_accept     <= 1'b0;
            r_total      <= '0;
            r_src_seg    <= '0;
            r_core_rst   <= 1'b1;
            r_core_start <= 1'b0;
            r_core_valid <= 1'b0;
            r_res_ready  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_core_rst   <= (w_next == S_CRST);
            r_core_start <= (w_next == S_CSTART);
            r_core_valid <= w_next_load;
            r_res_ready  <= (w_next == S_RESULT);
            r_src_seg    <= w_next_seg;
            r_done       <= 1'b0;

            if (w_next != r_state) begin
                r_idx <= '0;
                r_cnt <= '0;
            end else begin
                if (w_xfer) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                if ((r_state == S_CRST) || (r_state == S_GAP)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if ((w_next == S_GAP) && (r_state != S_GAP)) begin
                r_gap_tgt <= w_tgt;
            end

            if ((r_state == S_IDLE) && go) begin
                r_msg_len <= msg_len;
                r_accept  <= 1'b0;
                r_total   <= '0;
            end

            if (r_state == S_CSTART) begin
                r_cyc <= CYC_W'(1);
            end else if (w_in_run) begin
                r_cyc <= w_cyc_inc;
            end

            if ((r_state == S_RESULT) && res_valid) begin
                r_done   <= 1'b1;
                r_accept <= (res_data != W'(HIGH_PERF));
                r_total  <= w_cyc_inc;
            end
        end
    end

    // Data to the core: the latched length in MLEN, otherwise the source word.
    always_comb begin
        core_data = '0;
        if (r_state == S_MLEN) begin
            core_data = W'(r_msg_len);
        end else if (r_core_valid) begin
            core_data = src_data;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign accept       = r_accept;
    assign total_cycles = r_total;
    assign src_seg      = r_src_seg;
    assign src_idx      = r_idx[15:0];
    assign core_rst     = r_core_rst;
    assign core_start   = r_core_start;
    assign core_valid   = r_core_valid;
    assign res_ready    = r_res_ready;

endmodule

// File: doc/verify_sequencer.md
VERIFY_SEQUENCER -- requirements
Module: verify_sequencer

Interface
REQ-001 Parameter W, default 64, width in bits of every data word.
REQ-002 Parameter HIGH_PERF, default 1, core variant: 1 = high-performance load order, 0 = low-resource load order.
REQ-003 Parameters SEED_WORDS=4, Z_WORDS=80, T1_WORDS=40, H_WORDS=11, default lengths in words of rho/c, z, t1, h.
REQ-004 Parameter GAP_CYCLES, default 0, number of idle cycles inserted before MSG and, when HIGH_PERF=1, before H.
REQ-005 Parameter RST_CYCLES, default 4, number of cycles core_rst is held.
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 go  in  1  one-cycle request to run one verify; sampled only in IDLE.
REQ-009 msg_len  in  32  message length in bytes; latched on an accepted go.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when the verify completes.
REQ-012 accept  out  1  verdict; valid on the done cycle and held until the next accepted go.
REQ-013 total_cycles  out  32  cycles from the cycle after CORE_START to the done cycle; held like accept.
REQ-014 src_seg  out  3  segment selector: 0 rho, 1 c, 2 z, 3 t1, 4 h, 5 msg.
REQ-015 src_idx  out  16  word index within the segment.
REQ-016 src_data  in  W  word from a combinational source for (src_seg, src_idx).
REQ-017 core_rst  out  1  reset to the dilithium core.
REQ-018 core_start  out  1  start pulse to the core.
REQ-019 core_valid  out  1  valid for data to the core.
REQ-020 core_data  out  W  data to the core.
REQ-021 core_ready  in  1  the core accepts core_data.
REQ-022 res_valid  in  1  the core's verdict is valid.
REQ-023 res_data  in  W  the core's verdict word.
REQ-024 res_ready  out  1  the sequencer accepts the verdict.

Function
REQ-025 States are: IDLE, CRST, CSTART, RHO, C, Z, T1, MLEN, MSG, H, GAP, RESULT.
REQ-026 The load order for HIGH_PERF=1 is RHO, C, Z, T1, MLEN, GAP, MSG, GAP, H, RESULT.
REQ-027 The load order for HIGH_PERF=0 is RHO, T1, C, Z, H, MLEN, GAP, MSG, RESULT.
REQ-028 A GAP state whose length is 0 is skipped with no extra cycle.
REQ-029 IDLE with go=1 latches msg_len, enters CRST and asserts core_rst for exactly RST_CYCLES cycles.
REQ-030 After CRST, CSTART asserts core_start for one cycle, then the sequencer enters RHO.
REQ-031 In every load state except MLEN: core_valid=1, core_data=src_data, and src_seg/src_idx address the current word.
REQ-032 A word transfers on a cycle with core_valid and core_ready both high; the index advances only on a transfer.
REQ-033 The index resets to 0 on each segment change.
REQ-034 core_data stays stable while core_valid=1 and core_ready=0.
REQ-035 In MLEN, core_data = msg_len zero-extended to W bits; MLEN is exactly one transfer.
REQ-036 MSG sends ceil(msg_len*8/W) words; the last word transfers when (idx+1)*W >= msg_len*8.
REQ-037 When msg_len=0, MSG is skipped entirely and zero message words are sent.
REQ-038 In GAP, core_valid=0 for exactly GAP_CYCLES cycles.
REQ-039 In RESULT, res_ready=1; on res_valid, accept = (res_data != HIGH_PERF), done pulses, and the sequencer returns to IDLE.
REQ-040 total_cycles saturates at 2^32-1.
REQ-041 go is ignored while busy=1.
REQ-042 core_valid, res_ready and core_start are never high in the same cycle.

Reset
REQ-043 rst=1 in any state forces, on the next edge, IDLE, all indices and counters to 0, and busy=done=accept=core_start=core_valid=res_ready=0, total_cycles=0, core_rst=1.
REQ-044 core_rst is 1 for exactly one cycle after rst deasserts.
REQ-045 rst asserted mid-transfer drops core_valid on the next edge and issues no done.

Verification
REQ-046 Case 1: HIGH_PERF=1, msg_len=33, W=64, core_ready=1, GAP=0 -> segment sequence 4,4,80,40,1,5,11 words; res_data=0 gives accept=1 and one done pulse.
REQ-047 Case 2: HIGH_PERF=0, msg_len=8 -> sequence rho4,t1 40,c4,z80,h11,mlen1,msg1; res_data=1 gives accept=1, and res_data=0 gives accept=0.
REQ-048 Case 3: msg_len=0 -> the MLEN word is 0, no msg transfers, and the next segment follows MLEN immediately.
REQ-049 Case 4: core_ready toggling 1/0 randomly -> no word is dropped or duplicated, and core_data is stable while stalled.
REQ-050 Case 5: GAP_CYCLES=3 -> exactly 3 core_valid=0 cycles before MSG (and before H when HIGH_PERF=1), and total_cycles rises by 3 or 6.
REQ-051 Case 6: rst during Z at idx=17 -> IDLE next cycle, no done, and a following go runs cleanly from RHO idx 0.
